// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, opcode/funct constants, mux selects and ALU codes
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic       SA_PC = 1'b0;
    localparam logic       SA_A  = 1'b1;

    localparam logic [1:0] SB_B    = 2'b00;
    localparam logic [1:0] SB_4    = 2'b01;
    localparam logic [1:0] SB_IMM  = 2'b10;
    localparam logic [1:0] SB_IMM4 = 2'b11;

    localparam logic       EXT_SIGN = 1'b0;
    localparam logic       EXT_ZERO = 1'b1;

    localparam logic [1:0] PS_ALU = 2'b00;
    localparam logic [1:0] PS_OUT = 2'b01;
    localparam logic [1:0] PS_JMP = 2'b10;
    localparam logic [1:0] PS_A   = 2'b11;

    // R-type funct codes that go through EXEC_R (jr is routed separately)
    function automatic logic r_alu_funct(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: maps current state plus opcode/funct to the ALU operation
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o
);

    // add for address/PC arithmetic, sub for branch compare, funct/opcode for execute
    always_comb begin
        alu_ctrl_o = ALU_AND;
        case (state_i)
            S_FETCH, S_DECODE, S_MEM_ADDR: alu_ctrl_o = ALU_ADD;
            S_BRANCH: alu_ctrl_o = ALU_SUB;
            S_EXEC_R: alu_ctrl_o = funct_i == FN_SUB ? ALU_SUB :
                                   funct_i == FN_AND ? ALU_AND :
                                   funct_i == FN_OR  ? ALU_OR  :
                                   funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
            S_EXEC_I: alu_ctrl_o = opcode_i == OP_SLTI ? ALU_SLT :
                                   opcode_i == OP_ANDI ? ALU_AND :
                                   opcode_i == OP_ORI  ? ALU_OR  : ALU_ADD;
            default: alu_ctrl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control FSM driving datapath muxes and enables
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_sel,
    output logic [1:0] pc_source,
    output logic [2:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;

    assign state = state_q;

    mc_alu_dec u_alu_dec (
        .state_i    (state_q),
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_ctrl_o (alu_ctrl)
    );

    // state register; reset returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // next state and per-state controls; rst masks every write/strobe so an aborted instruction has no effect
    always_comb begin
        state_d    = S_FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = WD_ALU;
        alu_src_a  = SA_PC;
        alu_src_b  = SB_B;
        ext_sel    = EXT_SIGN;
        pc_source  = PS_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SB_4;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SB_IMM4;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        state_d    = funct == FN_JR ? S_JR : r_alu_funct(funct) ? S_EXEC_R : S_FETCH;
                        illegal    = !(funct == FN_JR || r_alu_funct(funct));
                        instr_done = illegal;
                    end
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J: state_d = S_JUMP;
                    OP_JAL: state_d = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
                state_d   = opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                mem_to_reg = WD_MDR;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                alu_src_a = SA_A;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_dst    = RD_RD;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
                ext_sel   = (opcode == OP_ANDI || opcode == OP_ORI) ? EXT_ZERO : EXT_SIGN;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SA_A;
                pc_source  = PS_OUT;
                pc_en      = opcode == OP_BNE ? !zero : zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = PS_JMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_source  = PS_JMP;
                pc_en      = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = WD_PC;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_source  = PS_A;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            mem_read   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-high reset.
REQ-002 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; both stable from DECODE until FETCH is re-entered.
REQ-003 zero  in  1  ALU zero flag; mem_ready  in  1  memory access completes this cycle.
REQ-004 pc_en  out  1  PC write enable; iord  out  1  memory address select (0 PC, 1 ALUOut); mem_read  out  1; mem_write  out  1; ir_write  out  1; reg_write  out  1.
REQ-005 reg_dst  out  2  register-number mux select: 00 rt, 01 rd, 10 const 31.
REQ-006 mem_to_reg  out  2  write-data mux select: 00 ALUOut, 01 MDR, 10 PC.
REQ-007 alu_src_a  out  1  (0 PC, 1 A); alu_src_b  out  2  (00 B, 01 const 4, 10 ext imm, 11 ext imm<<2); ext_sel  out  1  (0 sign, 1 zero).
REQ-008 pc_source  out  2  next-PC mux select: 00 ALU result, 01 ALUOut, 10 jump target, 11 A.
REQ-009 alu_ctrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-010 instr_done  out  1  one-cycle pulse on an instruction's last cycle; illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode/funct; state  out  4  current state (debug).

Function
REQ-011 Supported: R-type op 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08; lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D.
REQ-012 States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11, JAL 12, JR 13; codes 14-15 go to FETCH next cycle with all enables low.
REQ-013 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00; ir_write and pc_en =1 only when mem_ready=1; stay in FETCH while mem_ready=0, else DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, ext_sel=0, alu_ctrl=add (branch target into ALUOut); next state by opcode: lw/sw->MEM_ADDR, R-type->EXEC_R (jr->JR), beq/bne->BRANCH, j->JUMP, jal->JAL, immediate ALU->EXEC_I, unsupported->FETCH with illegal=1 and instr_done=1.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sel=0, alu_ctrl=add; next MEM_RD (lw) or MEM_WR (sw).
REQ-016 MEM_RD: iord=1, mem_read=1; hold until mem_ready=1, then WB_MEM. WB_MEM: reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1, next FETCH.
REQ-017 MEM_WR: iord=1, mem_write=1; hold until mem_ready=1, then FETCH with instr_done=1 in the mem_ready cycle.
REQ-018 EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct; next WB_R: reg_dst=01, mem_to_reg=00, reg_write=1, instr_done=1, next FETCH.
REQ-019 EXEC_I: alu_src_a=1, alu_src_b=10, ext_sel=1 for andi/ori else 0, alu_ctrl add/slt/and/or per opcode; next WB_I: reg_dst=00, mem_to_reg=00, reg_write=1, instr_done=1.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_source=01, pc_en=zero for beq and ~zero for bne (combinational on zero), instr_done=1, next FETCH.
REQ-021 JUMP: pc_source=10, pc_en=1, instr_done=1. JAL: same plus reg_dst=10, mem_to_reg=10, reg_write=1. JR: pc_source=11, pc_en=1, instr_done=1. All next FETCH.
REQ-022 Outputs not listed for a state SHALL be 0; mem_read/mem_write SHALL never both be 1.
REQ-023 Latency with mem_ready always 1: R-type/immediate 4 cycles, lw 5, sw 4, beq/bne/j/jal/jr 3.

Reset
REQ-024 While rst=1: state<=FETCH at the clock edge; pc_en, ir_write, reg_write, mem_write, mem_read, instr_done, illegal forced 0 combinationally.
REQ-025 rst asserted in any state, including mid memory wait, SHALL abort the instruction without any register-file, PC or memory write after that edge.

Structure
REQ-026 State codes, opcode/funct constants, mux select codes and alu_ctrl codes SHALL live in shared package mc_pkg.
REQ-027 ALU-control decode (opcode/funct/state -> alu_ctrl) SHALL be sub-module mc_alu_dec.

Verification
REQ-028 add (op 0, funct 0x20), mem_ready=1 -> states 0,1,6,7; WB_R reg_dst=01, reg_write=1, instr_done=1.
REQ-029 lw with mem_ready low 2 cycles in MEM_RD -> stays in 3 for 3 cycles total, WB_MEM mem_to_reg=01, 7 cycles total.
REQ-030 beq zero=1 -> pc_en=1, pc_source=01 in BRANCH; bne zero=1 -> pc_en=0.
REQ-031 jal -> JAL reg_dst=10, mem_to_reg=10, reg_write=1, pc_source=10, pc_en=1.
REQ-032 opcode 0x3F -> illegal=1 in DECODE, next state FETCH, no write enables.
REQ-033 rst pulsed during MEM_WR wait -> mem_write=0 that cycle, state=0 next cycle.
